dual_port_mem: RTL and testbench



---
 rtl/dual_port_mem.sv | 154 +++++++++++++++
 tb/tb_dual_port_mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem.sv
// rtl/dual_port_mem.sv - dual-port synchronous memory with read pipeline and optional clear sweep
//
// Purpose: word store behind the game logic (port A, read/write with byte
// enables) and the video fetch path (port B, read-only). Reads sample the
// array on the accept edge and then pass through READ_LATENCY-1 further
// register stages; each accepted read yields exactly one rvalid pulse.
// Optional feature macro: MEM_CLEAR_EN (zeroes the whole array after reset,
// one word per cycle, while busy is high).
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   a_req, a_wEn, a_addr,      port A request, write select, address,
//   a_be, a_dataIn             byte enables and write data
//   a_ready                    port A accepts requests (= !busy)
//   a_rvalid, a_dataOut        port A read return
//   b_req, b_addr              port B read request and address
//   b_rvalid, b_dataOut        port B read return
//   busy                       clear sweep in progress
module dual_port_mem #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDRESS_WIDTH = 12,
  parameter int    DEPTH         = 4096,
  parameter int    READ_LATENCY  = 1,
  parameter string MEMFILE       = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_req,
  input  logic                       a_wEn,
  input  logic [ADDRESS_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH/8-1:0]    a_be,
  input  logic [DATA_WIDTH-1:0]      a_dataIn,
  output logic                       a_ready,
  output logic                       a_rvalid,
  output logic [DATA_WIDTH-1:0]      a_dataOut,
  input  logic                       b_req,
  input  logic [ADDRESS_WIDTH-1:0]   b_addr,
  output logic                       b_rvalid,
  output logic [DATA_WIDTH-1:0]      b_dataOut,
  output logic                       busy
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2^ADDRESS_WIDTH, so the range check needs one extra bit.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_A = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear sweep control
  logic             clr_we;
  logic [IDX_W-1:0] clr_ptr;

`ifdef MEM_CLEAR_EN
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t           state, state_nx;
  logic [IDX_W-1:0] clr_ptr_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    clr_we     = 1'b0;
    busy       = 1'b0;
    case (state)
      S_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_ptr == CLR_LAST) state_nx = S_RUN;
        else                     clr_ptr_nx = clr_ptr + 1'b1;
      end
      default: ;
    endcase
  end
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_ptr = '0;
`endif

  assign a_ready = !busy;

  // Request decode
  logic             a_in_range, b_in_range;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic             a_wr, a_rd, b_rd;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

  assign a_in_range = {1'b0, a_addr} < DEPTH_A;
  assign b_in_range = {1'b0, b_addr} < DEPTH_A;
  assign a_idx      = a_addr[IDX_W-1:0];
  assign b_idx      = b_addr[IDX_W-1:0];
  assign a_wr       = a_req & a_ready & a_wEn & a_in_range;
  assign a_rd       = a_req & a_ready & ~a_wEn;
  assign b_rd       = b_req & ~busy;
  // Out-of-range reads return zero but still produce rvalid.
  assign a_rdata    = a_in_range ? mem[a_idx] : '0;
  assign b_rdata    = b_in_range ? mem[b_idx] : '0;

  // Array write port; no reset so contents survive rst_n (outside the sweep).
  // Reads sample mem before this update lands, giving read-before-write on
  // same-edge collisions and new data on the following edge.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (a_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_be[i]) mem[a_idx][i*8 +: 8] <= a_dataIn[i*8 +: 8];
      end
    end
  end

  // Read pipelines. Data stages only load behind a valid bit, so the last
  // stage holds its value while rvalid is low.
  logic [READ_LATENCY-1:0]                 a_vp, b_vp;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] a_dp, b_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vp <= '0;
      b_vp <= '0;
      a_dp <= '0;
      b_dp <= '0;
    end else begin
      a_vp[0] <= a_rd;
      b_vp[0] <= b_rd;
      if (a_rd) a_dp[0] <= a_rdata;
      if (b_rd) b_dp[0] <= b_rdata;
      for (int i = 1; i < READ_LATENCY; i++) begin
        a_vp[i] <= a_vp[i-1];
        b_vp[i] <= b_vp[i-1];
        if (a_vp[i-1]) a_dp[i] <= a_dp[i-1];
        if (b_vp[i-1]) b_dp[i] <= b_dp[i-1];
      end
    end
  end

  assign a_rvalid  = a_vp[READ_LATENCY-1];
  assign a_dataOut = a_dp[READ_LATENCY-1];
  assign b_rvalid  = b_vp[READ_LATENCY-1];
  assign b_dataOut = b_dp[READ_LATENCY-1];

endmodule

// File: tb/tb_dual_port_mem.sv
// tb/tb_dual_port_mem.sv - self-checking bench for dual_port_mem
module tb_dual_port_mem;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int RL    = 2;
`ifdef MEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_wEn;
  logic [AW-1:0] a_addr;
  logic [3:0]    a_be;
  logic [DW-1:0] a_dataIn;
  logic          a_ready, a_rvalid;
  logic [DW-1:0] a_dataOut;
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic          b_rvalid;
  logic [DW-1:0] b_dataOut;
  logic          busy;

  dual_port_mem #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL), .MEMFILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wEn(a_wEn), .a_addr(a_addr), .a_be(a_be), .a_dataIn(a_dataIn),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_dataOut(a_dataOut),
    .b_req(b_req), .b_addr(b_addr), .b_rvalid(b_rvalid), .b_dataOut(b_dataOut),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          busy_left = 0;
  logic [31:0] model [DEPTH];
  rd_t         qa[$], qb[$];
  logic [31:0] last_a = '0, last_b = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [AW-1:0] ad);
    return (int'(ad) < DEPTH) ? model[int'(ad)] : 32'h0;
  endfunction

  // One clock cycle: drive requests, update the model at the accept edge,
  // then compare every output against the model.
  task automatic step(input bit ar, input bit aw, input logic [AW-1:0] aad, input logic [3:0] be,
                      input logic [31:0] ad, input bit br, input logic [AW-1:0] bad);
    bit  rdy;
    rd_t e;
    a_req = ar; a_wEn = aw; a_addr = aad; a_be = be; a_dataIn = ad;
    b_req = br; b_addr = bad;
    rdy = (busy_left == 0);
    if (br && rdy) begin
      e.due = cyc + RL;
      e.d   = model_rd(bad);
      qb.push_back(e);
    end
    if (ar && rdy) begin
      if (!aw) begin
        e.due = cyc + RL;
        e.d   = model_rd(aad);
        qa.push_back(e);
      end else if (int'(aad) < DEPTH) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[int'(aad)][i*8 +: 8] = ad[i*8 +: 8];
      end
    end
    @(posedge clk);
    cyc++;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0)
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end
    #1;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      check("a_rvalid", a_rvalid, 1);
      check("a_dataOut", a_dataOut, qa[0].d);
      last_a = qa[0].d;
      void'(qa.pop_front());
    end else begin
      check("a_rvalid_idle", a_rvalid, 0);
      check("a_dataOut_hold", a_dataOut, last_a);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      check("b_rvalid", b_rvalid, 1);
      check("b_dataOut", b_dataOut, qb[0].d);
      last_b = qb[0].d;
      void'(qb.pop_front());
    end else begin
      check("b_rvalid_idle", b_rvalid, 0);
      check("b_dataOut_hold", b_dataOut, last_b);
    end
    check("busy", busy, busy_left > 0);
    check("a_ready", a_ready, busy_left == 0);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    #1;
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_dataOut", a_dataOut, 0);
    check("rst_b_dataOut", b_dataOut, 0);
    check("rst_busy", busy, CLR);
    check("rst_a_ready", a_ready, !CLR);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    busy_left = CLR ? DEPTH : 0;
  endtask

  task automatic rand_step(input bit force_b);
    step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)), $urandom, force_b || ($urandom_range(0, 1) == 1),
         AW'($urandom_range(0, 15)));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst_n = 1'b0; a_req = 0; a_wEn = 0; a_addr = '0; a_be = '0; a_dataIn = '0;
    b_req = 0; b_addr = '0;
    #2;
    do_reset();
    while (busy_left > 0) rand_step(1'b1);

    // Fill every word so later reads have defined contents.
    for (int i = 0; i < DEPTH; i++) step(1, 1, AW'(i), 4'hF, $urandom, 0, '0);

    // Read-after-write
    step(1, 1, 4'd3, 4'hF, 32'hDEADBEEF, 0, '0);
    step(1, 0, 4'd3, 4'h0, '0, 0, '0);
    idle();
    check("raw_const", a_dataOut, 32'hDEADBEEF);
    idle();

    // Byte enables
    step(1, 1, 4'd3, 4'b0101, 32'h11223344, 0, '0);
    step(1, 0, 4'd3, 4'h0, '0, 0, '0);
    idle();
    check("be_const", a_dataOut, 32'hDE22BE44);

    // Zero byte enable is a no-op
    step(1, 1, 4'd3, 4'b0000, 32'h55555555, 0, '0);
    step(1, 0, 4'd3, 4'h0, '0, 0, '0);
    idle();
    check("be0_const", a_dataOut, 32'hDE22BE44);

    // Collision: B sees old data on the same edge, new data one edge later
    step(1, 1, 4'd5, 4'hF, 32'h0, 0, '0);
    step(1, 1, 4'd5, 4'hF, 32'hCAFEF00D, 1, 4'd5);
    step(0, 0, '0, '0, '0, 1, 4'd5);
    check("coll_old", b_dataOut, 32'h0);
    idle();
    check("coll_new", b_dataOut, 32'hCAFEF00D);

    // Out-of-range write dropped, read returns zero with rvalid
    step(1, 1, 4'd13, 4'hF, 32'hFFFFFFFF, 0, '0);
    step(1, 0, 4'd13, 4'h0, '0, 0, '0);
    idle();
    check("oor_rvalid", a_rvalid, 1);
    check("oor_zero", a_dataOut, 32'h0);

    // Pipelined B burst, then a burst cut by reset
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, '0, 1, AW'(i));
    repeat (3) idle();
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, '0, 1, AW'(i));
    do_reset();
    while (busy_left > 0) rand_step(1'b1);
    repeat (4) idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) rand_step(1'b0);
    repeat (RL + 1) idle();

`ifdef MEM_CLEAR_EN
    // Reset part-way through the sweep restarts it from the beginning
    do_reset();
    repeat (DEPTH / 2) rand_step(1'b1);
    do_reset();
    while (busy_left > 0) rand_step(1'b1);
    step(1, 0, 4'd3, 4'h0, '0, 0, '0);
    idle();
    check("sweep_zero", a_dataOut, 32'h0);
    repeat (2) idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
